eth_byte_uart_tx: RTL and testbench

- Downstream consumer of the Ethernet receive stage. Takes the received byte stream (byte plus one-cycle strobe) in the PHY receive clock domain and buffers it in a FIFO.
- Serialises the buffered bytes onto a UART line as 8N1: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Bytes are dropped when the FIFO is full, and drops are counted. The block completes the rx_eth→uart path in the top level.

---
 rtl/eth_byte_uart_tx_if.sv | 33 +++
 rtl/eth_byte_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_eth_byte_uart_tx.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_byte_uart_tx_if.sv
// Byte-stream and status bundle between the Ethernet receive stage and the UART transmitter.
// The slave modport is the transmitter; the master modport is the byte producer.
interface eth_byte_uart_tx_if #(
  parameter int unsigned FIFO_AW = 11
) ();
  logic [7:0]       rx_data_in;
  logic             rx_byte_valid;
  logic             uart_txd;
  logic             tx_busy;
  logic [FIFO_AW:0] fifo_count;
  logic             fifo_full;
  logic [15:0]      overflow_cnt;

  modport master (
    output rx_data_in,
    output rx_byte_valid,
    input  uart_txd,
    input  tx_busy,
    input  fifo_count,
    input  fifo_full,
    input  overflow_cnt
  );

  modport slave (
    input  rx_data_in,
    input  rx_byte_valid,
    output uart_txd,
    output tx_busy,
    output fifo_count,
    output fifo_full,
    output overflow_cnt
  );
endinterface

// File: rtl/eth_byte_uart_tx.sv
// Buffers received Ethernet bytes in a FIFO and serialises them as 8N1 UART characters.
// Bytes arriving while the FIFO is full are dropped and counted (saturating).
module eth_byte_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_AW      = 11
) (
  input  logic                phy_rx_clk,
  input  logic                reset_n,
  eth_byte_uart_tx_if.slave   io_bus
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast  = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] CountFull = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StData,
    StStop
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]         r_mem [Depth];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic [7:0]         r_rd_data;
  logic [15:0]        r_ovf;

  // Transmitter state
  state_e             r_state;
  logic [BaudW-1:0]   r_baud;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               r_txd;

  logic               w_full;
  logic               w_push;
  logic               w_drop;
  logic               w_pop;
  logic               w_baud_done;
  logic [FIFO_AW:0]   w_count_nxt;
  logic [15:0]        w_ovf_nxt;
  state_e             w_state_nxt;
  logic [BaudW-1:0]   w_baud_nxt;
  logic [2:0]         w_bit_nxt;
  logic [7:0]         w_shift_nxt;
  logic               w_txd_nxt;

  // Full is taken from the registered count, so a pop in the same cycle never frees a slot.
  always_comb begin
    w_full      = (r_count == CountFull);
    w_push      = io_bus.rx_byte_valid & ~w_full;
    w_drop      = io_bus.rx_byte_valid & w_full;
    w_pop       = (r_state == StIdle) && (r_count != '0);
    w_baud_done = (r_baud == BaudLast);
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_ovf_nxt = r_ovf;
    if (w_drop && (r_ovf != 16'hFFFF)) begin
      w_ovf_nxt = r_ovf + 16'd1;
    end
  end

  // Output bit is registered from the current state, so the line lags the FSM by one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + 1'b1;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_txd_nxt   = 1'b1;
    unique case (r_state)
      StIdle: begin
        w_baud_nxt = '0;
        if (w_pop) begin
          w_state_nxt = StLoad;
        end
      end
      StLoad: begin
        w_baud_nxt  = '0;
        w_shift_nxt = r_rd_data;
        w_bit_nxt   = '0;
        w_state_nxt = StStart;
      end
      StStart: begin
        w_txd_nxt = 1'b0;
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_state_nxt = StData;
        end
      end
      StData: begin
        w_txd_nxt = r_shift[0];
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = StStop;
          end else begin
            w_bit_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
      StStop: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_baud_nxt  = '0;
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge phy_rx_clk) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= '0;
      r_state   <= StIdle;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count   <= w_count_nxt;
      r_ovf     <= w_ovf_nxt;
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_txd     <= w_txd_nxt;
    end
  end

  // Unreset RAM with a registered read port; stale contents are unreachable after reset.
  always_ff @(posedge phy_rx_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= io_bus.rx_data_in;
    end
    if (w_pop) begin
      r_rd_data <= r_mem[r_rd_ptr];
    end
  end

  assign io_bus.uart_txd     = r_txd;
  assign io_bus.tx_busy      = (r_state != StIdle);
  assign io_bus.fifo_count   = r_count;
  assign io_bus.fifo_full    = w_full;
  assign io_bus.overflow_cnt = r_ovf;

endmodule

// File: tb/tb_eth_byte_uart_tx.sv
// Scoreboard bench: stimulus pushes expected characters, per-DUT UART monitors pop and compare
// the line waveform cycle by cycle. Three instances cover the default, small-FIFO and saturation cases.
module tb_eth_byte_uart_tx;

  localparam int CpbA = 4;
  localparam int CpbB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n [3] = '{1'b0, 1'b0, 1'b0};
  logic       v_w   [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] d_w   [3] = '{8'h00, 8'h00, 8'h00};
  logic       txd_w [2];
  int         rst_edges [2] = '{0, 0};

  logic [7:0] exp_q [2][$];
  int         st_q  [2][$];

  bit c_done = 1'b0;
  bit pk_en  = 1'b0;
  int pk     = 0;

  eth_byte_uart_tx_if #(.FIFO_AW(11)) if_a ();
  eth_byte_uart_tx_if #(.FIFO_AW(3))  if_b ();
  eth_byte_uart_tx_if #(.FIFO_AW(1))  if_c ();

  assign if_a.rx_data_in    = d_w[0];
  assign if_a.rx_byte_valid = v_w[0];
  assign if_b.rx_data_in    = d_w[1];
  assign if_b.rx_byte_valid = v_w[1];
  assign if_c.rx_data_in    = d_w[2];
  assign if_c.rx_byte_valid = v_w[2];
  assign txd_w[0] = if_a.uart_txd;
  assign txd_w[1] = if_b.uart_txd;

  eth_byte_uart_tx #(.CLKS_PER_BIT(CpbA), .FIFO_AW(11)) dut_a (
    .phy_rx_clk (clk),
    .reset_n    (rst_n[0]),
    .io_bus     (if_a)
  );

  eth_byte_uart_tx #(.CLKS_PER_BIT(CpbB), .FIFO_AW(3)) dut_b (
    .phy_rx_clk (clk),
    .reset_n    (rst_n[1]),
    .io_bus     (if_b)
  );

  eth_byte_uart_tx #(.CLKS_PER_BIT(65535), .FIFO_AW(1)) dut_c (
    .phy_rx_clk (clk),
    .reset_n    (rst_n[2]),
    .io_bus     (if_c)
  );

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) rst_edges[i] <= rst_edges[i] + 1;
    end
  end

  always @(negedge clk) begin
    if (pk_en && (int'(if_a.fifo_count) > pk)) pk <= int'(if_a.fifo_count);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Drives consecutive one-cycle strobes; t0 is the index of the edge that takes the first byte.
  task automatic burst(input int id, input logic [7:0] bq[$], output int t0);
    t0 = 0;
    for (int i = 0; i < bq.size(); i++) begin
      @(negedge clk);
      if (i == 0) t0 = cyc + 1;
      v_w[id] = 1'b1;
      d_w[id] = bq[i];
    end
    @(negedge clk);
    v_w[id] = 1'b0;
  endtask

  // Checks each character against the next scoreboard entry for all 10*cpb line cycles.
  task automatic mon(input int id, input int cpb);
    logic [9:0] frame;
    logic [7:0] eb;
    int         r0;
    bit         ok;
    bit         have;
    forever begin
      @(negedge clk);
      if (txd_w[id] === 1'b0) begin
        st_q[id].push_back(cyc);
        r0   = rst_edges[id];
        have = (exp_q[id].size() != 0);
        eb   = 8'h00;
        if (have) eb = exp_q[id].pop_front();
        frame = {1'b1, eb, 1'b0};
        ok = 1'b1;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < cpb; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (rst_edges[id] == r0 && txd_w[id] !== frame[b]) ok = 1'b0;
          end
        end
        if (rst_edges[id] == r0) begin
          if (!have) chk($sformatf("mon%0d_unexpected_char", id), 32'd1, 32'd0);
          else chk($sformatf("mon%0d_char_%02h_waveform_ok", id, eb), 32'(ok), 32'd1);
        end
      end
    end
  endtask

  initial mon(0, CpbA);
  initial mon(1, CpbB);

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation exceeded 200000 cycles");
    $fatal(1, "watchdog");
  end

  // Saturation: one queued byte keeps the transmitter busy for the whole run, so every strobe
  // after the first three is a drop.
  initial begin
    repeat (4) @(negedge clk);
    rst_n[2] = 1'b1;
    d_w[2]   = 8'h5A;
    @(negedge clk);
    v_w[2] = 1'b1;
    repeat (65537) @(negedge clk);
    chk("t6_full", 32'(if_c.fifo_full), 32'd1);
    chk("t6_ovf_before_sat", 32'(if_c.overflow_cnt), 32'h0000FFFE);
    @(negedge clk);
    chk("t6_ovf_sat", 32'(if_c.overflow_cnt), 32'h0000FFFF);
    repeat (100) @(negedge clk);
    chk("t6_ovf_hold", 32'(if_c.overflow_cnt), 32'h0000FFFF);
    chk("t6_count", 32'(if_c.fifo_count), 32'd2);
    v_w[2] = 1'b0;
    c_done = 1'b1;
  end

  initial begin
    logic [7:0] bq[$];
    int t;
    bit found;

    repeat (4) @(negedge clk);
    chk("rst_txd", 32'(if_a.uart_txd), 32'd1);
    chk("rst_busy", 32'(if_a.tx_busy), 32'd0);
    chk("rst_count", 32'(if_a.fifo_count), 32'd0);
    chk("rst_full", 32'(if_a.fifo_full), 32'd0);
    chk("rst_ovf", 32'(if_a.overflow_cnt), 32'd0);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (3) @(negedge clk);

    // Test 1: single 8'hA5
    exp_q[0].push_back(8'hA5);
    bq.delete(); bq.push_back(8'hA5);
    burst(0, bq, t);
    chk("t1_count_after_write", 32'(if_a.fifo_count), 32'd1);
    @(negedge clk);
    chk("t1_busy_after_pop", 32'(if_a.tx_busy), 32'd1);
    chk("t1_count_after_pop", 32'(if_a.fifo_count), 32'd0);
    repeat (48) @(negedge clk);
    chk("t1_nstarts", 32'(st_q[0].size()), 32'd1);
    if (st_q[0].size() == 1) chk("t1_start_latency", 32'(st_q[0][0] - t), 32'd3);
    chk("t1_busy_end", 32'(if_a.tx_busy), 32'd0);
    chk("t1_txd_idle", 32'(if_a.uart_txd), 32'd1);
    chk("t1_scoreboard_empty", 32'(exp_q[0].size()), 32'd0);

    // Test 2: back-to-back burst
    st_q[0].delete();
    bq.delete(); bq.push_back(8'h00); bq.push_back(8'hFF); bq.push_back(8'h55);
    foreach (bq[i]) exp_q[0].push_back(bq[i]);
    pk = 0;
    pk_en = 1'b1;
    burst(0, bq, t);
    repeat (5) @(negedge clk);
    pk_en = 1'b0;
    chk("t2_count_peak", 32'(pk), 32'd2);
    repeat (3 * 42 + 10) @(negedge clk);
    chk("t2_nstarts", 32'(st_q[0].size()), 32'd3);
    if (st_q[0].size() == 3) begin
      chk("t2_start0", 32'(st_q[0][0] - t), 32'd3);
      chk("t2_spacing01", 32'(st_q[0][1] - st_q[0][0]), 32'd42);
      chk("t2_spacing12", 32'(st_q[0][2] - st_q[0][1]), 32'd42);
    end
    chk("t2_scoreboard_empty", 32'(exp_q[0].size()), 32'd0);

    // Test 5: reset in the middle of a data bit with bytes queued
    bq.delete(); bq.push_back(8'h11); bq.push_back(8'h22); bq.push_back(8'h33);
    bq.push_back(8'h44);
    exp_q[0].push_back(8'h11);
    burst(0, bq, t);
    repeat (16) @(negedge clk);
    chk("t5_txd_before_reset", 32'(if_a.uart_txd), 32'd0);
    chk("t5_count_before_reset", 32'(if_a.fifo_count), 32'd3);
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    chk("t5_txd_after_reset", 32'(if_a.uart_txd), 32'd1);
    chk("t5_busy_after_reset", 32'(if_a.tx_busy), 32'd0);
    chk("t5_count_after_reset", 32'(if_a.fifo_count), 32'd0);
    chk("t5_ovf_after_reset", 32'(if_a.overflow_cnt), 32'd0);
    repeat (60) @(negedge clk);
    chk("t5_scoreboard_empty", 32'(exp_q[0].size()), 32'd0);
    st_q[0].delete();
    exp_q[0].push_back(8'h3C);
    bq.delete(); bq.push_back(8'h3C);
    burst(0, bq, t);
    repeat (48) @(negedge clk);
    chk("t5_nstarts", 32'(st_q[0].size()), 32'd1);
    if (st_q[0].size() == 1) chk("t5_start_latency", 32'(st_q[0][0] - t), 32'd3);
    chk("t5_3c_sent", 32'(exp_q[0].size()), 32'd0);

    // Test 3: 12 writes into an 8-deep FIFO behind a busy transmitter
    bq.delete();
    for (int i = 0; i < 12; i++) bq.push_back(8'hC0 + 8'(i));
    for (int i = 0; i < 9; i++) exp_q[1].push_back(bq[i]);
    burst(1, bq, t);
    chk("t3_count", 32'(if_b.fifo_count), 32'd8);
    chk("t3_full", 32'(if_b.fifo_full), 32'd1);
    chk("t3_ovf", 32'(if_b.overflow_cnt), 32'd3);
    repeat (9 * 162 + 40) @(negedge clk);
    chk("t3_scoreboard_empty", 32'(exp_q[1].size()), 32'd0);
    chk("t3_count_drained", 32'(if_b.fifo_count), 32'd0);
    chk("t3_busy_end", 32'(if_b.tx_busy), 32'd0);

    // Test 4: write coinciding with the IDLE pop of a full FIFO
    bq.delete();
    for (int i = 0; i < 9; i++) bq.push_back(8'hF0 + 8'(i));
    foreach (bq[i]) exp_q[1].push_back(bq[i]);
    burst(1, bq, t);
    chk("t4_full", 32'(if_b.fifo_full), 32'd1);
    chk("t4_count_full", 32'(if_b.fifo_count), 32'd8);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (if_b.tx_busy == 1'b0) found = 1'b1;
    end
    chk("t4_idle_reached", 32'(found), 32'd1);
    if (found) begin
      v_w[1] = 1'b1;
      d_w[1] = 8'hEE;
      @(negedge clk);
      v_w[1] = 1'b0;
      chk("t4_ovf_inc", 32'(if_b.overflow_cnt), 32'd4);
      chk("t4_count_dec", 32'(if_b.fifo_count), 32'd7);
    end
    repeat (9 * 162 + 40) @(negedge clk);
    chk("t4_scoreboard_empty", 32'(exp_q[1].size()), 32'd0);
    chk("t4_ovf_final", 32'(if_b.overflow_cnt), 32'd4);

    wait (c_done);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
